// File: rtl/stopwatch_control.sv
// ---------------------------------------------------------------------------
// stopwatch_control
//   Moore control unit for the stopwatch datapath. Synchronizes and
//   edge-detects the three user buttons, remembers presses that cannot be
//   serviced on the cycle they arrive, and sequences run / lap / clear.
//
// Ports
//   clk      in   system clock, rising edge
//   resetn   in   asynchronous active-low reset
//   ss_btn   in   raw start/stop button (asynchronous)
//   lap_btn  in   raw lap button (asynchronous)
//   clr_btn  in   raw clear button (asynchronous)
//   tenth    in   datapath tenth-counter terminal count (level, clk domain)
//   cw       out  control word to the datapath
//                 [5] display mux, [4] lap load, [3] counter sync reset,
//                 [2] counter enable, [1:0] tenth counter op
//   state    out  current state encoding (debug / LEDs)
//   running  out  high while the stopwatch is counting
// ---------------------------------------------------------------------------
module stopwatch_control #(
  parameter int CW_WIDTH       = 6,    // only 6 is supported
  parameter bit BTN_ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ss_btn,
  input  logic                lap_btn,
  input  logic                clr_btn,
  input  logic                tenth,
  output logic [CW_WIDTH-1:0] cw,
  output logic [2:0]          state,
  output logic                running
);

  // Bit positions of the buttons inside the 3-bit button vectors.
  localparam int B_SS  = 0;
  localparam int B_LAP = 1;
  localparam int B_CLR = 2;

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_STOP    = 3'd1,
    S_RUN     = 3'd2,
    S_INC     = 3'd3,
    S_R2LR    = 3'd4,
    S_LAPRUN  = 3'd5,
    S_LAPINC  = 3'd6,
    S_LAPSTOP = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] w_btn;
  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic [2:0] r_s3;
  logic [2:0] w_pulse;
  logic [2:0] r_pend;
  logic [2:0] w_req;
  logic [2:0] w_keep;
  logic [5:0] w_cw;

  assign w_btn = {clr_btn, lap_btn, ss_btn} ^ {3{BTN_ACTIVE_LOW}};

  // Two-flop synchronizer followed by a previous-value flop for edge detect.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_pulse = r_s2 & ~r_s3;
  // A request is either a fresh press or one still waiting for service.
  assign w_req   = w_pulse | r_pend;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_RESET;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_req & w_keep;
    end
  end

  // Next state. w_keep marks which requests survive this cycle: a bit is
  // cleared when the request is consumed or when this state discards it.
  always_comb begin
    w_state_nxt = r_state;
    w_keep      = 3'b111;
    unique case (r_state)
      S_RESET: begin
        w_state_nxt = S_STOP;
        w_keep      = 3'b000;
      end
      S_STOP: begin
        w_keep[B_LAP] = 1'b0;
        if (w_req[B_CLR]) begin
          w_state_nxt   = S_RESET;
          w_keep[B_CLR] = 1'b0;
        end else if (w_req[B_SS]) begin
          w_state_nxt  = S_RUN;
          w_keep[B_SS] = 1'b0;
        end
      end
      S_RUN: begin
        w_keep[B_CLR] = 1'b0;
        // A tick always wins so no tenth is lost; buttons wait a cycle.
        if (tenth) begin
          w_state_nxt = S_INC;
        end else if (w_req[B_SS]) begin
          w_state_nxt  = S_STOP;
          w_keep[B_SS] = 1'b0;
        end else if (w_req[B_LAP]) begin
          w_state_nxt   = S_R2LR;
          w_keep[B_LAP] = 1'b0;
        end
      end
      S_INC:    w_state_nxt = S_RUN;
      S_R2LR:   w_state_nxt = S_LAPRUN;
      S_LAPRUN: begin
        w_keep[B_CLR] = 1'b0;
        if (tenth) begin
          w_state_nxt = S_LAPINC;
        end else if (w_req[B_SS]) begin
          w_state_nxt  = S_LAPSTOP;
          w_keep[B_SS] = 1'b0;
        end else if (w_req[B_LAP]) begin
          w_state_nxt   = S_RUN;
          w_keep[B_LAP] = 1'b0;
        end
      end
      S_LAPINC: w_state_nxt = S_LAPRUN;
      S_LAPSTOP: begin
        if (w_req[B_CLR]) begin
          w_state_nxt   = S_RESET;
          w_keep[B_CLR] = 1'b0;
        end else if (w_req[B_SS]) begin
          w_state_nxt  = S_LAPRUN;
          w_keep[B_SS] = 1'b0;
        end else if (w_req[B_LAP]) begin
          w_state_nxt   = S_STOP;
          w_keep[B_LAP] = 1'b0;
        end
      end
      default: w_state_nxt = S_RESET;
    endcase
  end

  // Moore decode of the control word straight from the state register.
  always_comb begin
    w_cw = 6'b000000;
    unique case (r_state)
      S_RESET:   w_cw = 6'b001011;
      S_STOP:    w_cw = 6'b000000;
      S_RUN:     w_cw = 6'b000010;
      S_INC:     w_cw = 6'b000111;
      S_R2LR:    w_cw = 6'b110000;
      S_LAPRUN:  w_cw = 6'b100010;
      S_LAPINC:  w_cw = 6'b100111;
      S_LAPSTOP: w_cw = 6'b100000;
      default:   w_cw = 6'b001011;
    endcase
  end

  assign cw      = CW_WIDTH'(w_cw);
  assign state   = r_state;
  assign running = (r_state == S_RUN)    || (r_state == S_INC)    ||
                   (r_state == S_R2LR)   || (r_state == S_LAPRUN) ||
                   (r_state == S_LAPINC);

endmodule
